// File: rtl/fsm_pkg.sv
// Shared state encoding and sizing helper for the pulse stretcher FSM.
// State values are fixed so the encoding stays stable for legacy consumers.
package fsm_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HIGH = ST_HIGH,
        GAP  = ST_GAP
    } pulse_state_t;

    // Gap counter width; a zero-length gap still needs a 1-bit register.
    function automatic int gap_width(input int gap_cyc);
        return (gap_cyc < 1) ? 1 : $clog2(gap_cyc + 1);
    endfunction

endpackage

// File: rtl/pulse_down_cnt.sv
// Loadable unsigned down-counter with a zero flag; holds at zero unless reloaded.
module pulse_down_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over decrement so a retrigger on the final count restarts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretch_fsm.sv
// Stretches single-cycle triggers into len-cycle high windows followed by a
// fixed forced-low gap, optionally retriggerable, flagging ignored triggers.
module pulse_stretch_fsm
    import fsm_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic [WIDTH-1:0] len,
    input  logic             retrig_en,
    output logic             level_out,
    output logic             busy,
    output logic             dropped
);

    localparam int GAP_W = gap_width(GAP_CYC);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    pulse_state_t     state;
    pulse_state_t     state_next;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_next;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             len_ok;
    logic             level_next;
    logic             busy_next;
    logic             dropped_next;

    assign len_ok = (len != '0);

    pulse_down_cnt #(
        .WIDTH(WIDTH)
    ) u_high_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .value(len - WIDTH'(1)),
        .dec  (cnt_dec),
        .zero (cnt_zero)
    );

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        state_next   = state;
        gap_next     = gap_cnt;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        dropped_next = 1'b0;

        case (state)
            IDLE: begin
                if (pulse_in) begin
                    if (len_ok) begin
                        state_next = HIGH;
                        cnt_load   = 1'b1;
                    end else begin
                        dropped_next = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (pulse_in && retrig_en && len_ok) begin
                    cnt_load = 1'b1;
                end else begin
                    dropped_next = pulse_in;
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (GAP_CYC > 0) begin
                        state_next = GAP;
                        gap_next   = GAP_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                dropped_next = pulse_in;
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        level_next = (state_next == HIGH);
        busy_next  = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            level_out <= 1'b0;
            busy      <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            state     <= state_next;
            gap_cnt   <= gap_next;
            level_out <= level_next;
            busy      <= busy_next;
            dropped   <= dropped_next;
        end
    end

endmodule

// File: tb/tb_pulse_stretch_fsm.sv
// Testbench for pulse_stretch_fsm: directed scenarios plus random traffic
// checked against a timeline model of high windows and gaps.
module tb_pulse_stretch_fsm;

    localparam int WIDTH   = 8;
    localparam int GAP_CYC = 2;

    logic             clk;
    logic             rst;
    logic             pulse_in;
    logic [WIDTH-1:0] len;
    logic             retrig_en;
    logic             level_out;
    logic             busy;
    logic             dropped;

    int       total;
    int       bad;
    int       cyc;
    int       win_end;
    logic [2:0] exp_out;

    pulse_stretch_fsm #(
        .WIDTH  (WIDTH),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .len      (len),
        .retrig_en(retrig_en),
        .level_out(level_out),
        .busy     (busy),
        .dropped  (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // The model only remembers the last cycle of the current high window;
    // the gap is the GAP_CYC cycles after it.
    task automatic model_reset();
        win_end = -1000;
        exp_out = 3'b000;
    endtask

    task automatic model_step(input logic p, input logic [WIDTH-1:0] l, input logic r);
        logic drop;
        drop = 1'b0;
        if (cyc <= win_end) begin
            if (p) begin
                if (r && l != 0) win_end = cyc + int'(l);
                else drop = 1'b1;
            end
        end else if (cyc <= win_end + GAP_CYC) begin
            drop = p;
        end else if (p) begin
            if (l != 0) win_end = cyc + int'(l);
            else drop = 1'b1;
        end
        exp_out = {(cyc + 1 <= win_end), (cyc + 1 <= win_end + GAP_CYC), drop};
    endtask

    task automatic drive_cycle(input logic p, input logic [WIDTH-1:0] l, input logic r);
        pulse_in  = p;
        len       = l;
        retrig_en = r;
        model_step(p, l, r);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if ({level_out, busy, dropped} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_async got=%b expected=000", {level_out, busy, dropped});
        end
        @(posedge clk);
        #1;
        total++;
        if ({level_out, busy, dropped} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_held got=%b expected=000", {level_out, busy, dropped});
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        int n_high;
        int n_busy;
        n_high = 0;
        n_busy = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(i == 0, 8'd3, 1'b0);
            total++;
            if ({level_out, busy, dropped} !== exp_out) begin
                bad++;
                $display("[TB] FAIL single cyc=%0d got=%b expected=%b", cyc, {level_out, busy, dropped}, exp_out);
            end
            n_high += int'(level_out);
            n_busy += int'(busy);
        end
        total++;
        if (n_high != 3 || n_busy != 5) begin
            bad++;
            $display("[TB] FAIL single_counts high=%0d busy=%0d expected high=3 busy=5", n_high, n_busy);
        end
    endtask

    task automatic test_retrig(input logic r);
        int n_high;
        int n_drop;
        n_high = 0;
        n_drop = 0;
        for (int i = 0; i < 14; i++) begin
            drive_cycle(i == 0 || i == 3, 8'd5, r);
            total++;
            if ({level_out, busy, dropped} !== exp_out) begin
                bad++;
                $display("[TB] FAIL retrig%0d cyc=%0d got=%b expected=%b", r, cyc, {level_out, busy, dropped}, exp_out);
            end
            n_high += int'(level_out);
            n_drop += int'(dropped);
        end
        total++;
        if (n_high != (r ? 8 : 5) || n_drop != (r ? 0 : 1)) begin
            bad++;
            $display("[TB] FAIL retrig%0d_counts high=%0d drop=%0d expected high=%0d drop=%0d",
                     r, n_high, n_drop, r ? 8 : 5, r ? 0 : 1);
        end
    endtask

    task automatic test_gap_drop();
        int n_high;
        int n_drop;
        n_high = 0;
        n_drop = 0;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(i == 0 || i == 4 || i == 5, 8'd2, 1'b1);
            total++;
            if ({level_out, busy, dropped} !== exp_out) begin
                bad++;
                $display("[TB] FAIL gap_drop cyc=%0d got=%b expected=%b", cyc, {level_out, busy, dropped}, exp_out);
            end
            n_high += int'(level_out);
            n_drop += int'(dropped);
        end
        total++;
        if (n_high != 4 || n_drop != 1) begin
            bad++;
            $display("[TB] FAIL gap_drop_counts high=%0d drop=%0d expected high=4 drop=1", n_high, n_drop);
        end
    endtask

    task automatic test_back_to_back();
        int n_drop;
        n_drop = 0;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(i <= 3, 8'd6, 1'b0);
            total++;
            if ({level_out, busy, dropped} !== exp_out) begin
                bad++;
                $display("[TB] FAIL back_to_back cyc=%0d got=%b expected=%b", cyc, {level_out, busy, dropped}, exp_out);
            end
            n_drop += int'(dropped);
        end
        total++;
        if (n_drop != 3) begin
            bad++;
            $display("[TB] FAIL back_to_back_drops got=%0d expected=3", n_drop);
        end
    endtask

    task automatic test_len_limits();
        int n_high;
        int n_busy;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(i == 0, 8'd0, 1'b1);
            total++;
            if ({level_out, busy, dropped} !== exp_out) begin
                bad++;
                $display("[TB] FAIL len_zero cyc=%0d got=%b expected=%b", cyc, {level_out, busy, dropped}, exp_out);
            end
        end
        n_high = 0;
        n_busy = 0;
        for (int i = 0; i < 262; i++) begin
            drive_cycle(i == 0, (i == 0) ? 8'd255 : 8'(i), 1'b0);
            total++;
            if ({level_out, busy, dropped} !== exp_out) begin
                bad++;
                $display("[TB] FAIL len_max cyc=%0d got=%b expected=%b", cyc, {level_out, busy, dropped}, exp_out);
            end
            n_high += int'(level_out);
            n_busy += int'(busy);
        end
        total++;
        if (n_high != 255 || n_busy != 257) begin
            bad++;
            $display("[TB] FAIL len_max_counts high=%0d busy=%0d expected high=255 busy=257", n_high, n_busy);
        end
    endtask

    task automatic test_reset_mid_high();
        int n_high;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(i == 0, 8'd10, 1'b0);
            total++;
            if ({level_out, busy, dropped} !== exp_out) begin
                bad++;
                $display("[TB] FAIL pre_reset cyc=%0d got=%b expected=%b", cyc, {level_out, busy, dropped}, exp_out);
            end
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({level_out, busy, dropped} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_mid_high got=%b expected=000", {level_out, busy, dropped});
        end
        model_reset();
        pulse_in = 1'b1;
        len      = 8'd9;
        @(posedge clk);
        #1;
        cyc++;
        total++;
        if ({level_out, busy, dropped} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_hold_trigger got=%b expected=000", {level_out, busy, dropped});
        end
        rst = 1'b0;
        n_high = 0;
        for (int i = 0; i < 9; i++) begin
            drive_cycle(i == 0, 8'd4, 1'b0);
            total++;
            if ({level_out, busy, dropped} !== exp_out) begin
                bad++;
                $display("[TB] FAIL post_reset cyc=%0d got=%b expected=%b", cyc, {level_out, busy, dropped}, exp_out);
            end
            n_high += int'(level_out);
        end
        total++;
        if (n_high != 4) begin
            bad++;
            $display("[TB] FAIL post_reset_window high=%0d expected=4", n_high);
        end
    endtask

    task automatic test_random();
        logic             p;
        logic [WIDTH-1:0] l;
        logic             r;
        for (int i = 0; i < 600; i++) begin
            p = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            r = 1'($urandom_range(0, 1));
            drive_cycle(p, l, r);
            total++;
            if ({level_out, busy, dropped} !== exp_out) begin
                bad++;
                $display("[TB] FAIL random cyc=%0d got=%b expected=%b", cyc, {level_out, busy, dropped}, exp_out);
            end
        end
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, 8'd0, 1'b0);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        rst       = 1'b0;
        pulse_in  = 1'b0;
        len       = '0;
        retrig_en = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_single();
        test_retrig(1'b1);
        test_retrig(1'b0);
        test_gap_drop();
        test_back_to_back();
        test_len_limits();
        test_reset_mid_high();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretch_fsm.md
PULSE_STRETCH_FSM -- requirements
Module: pulse_stretch_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of length field and internal counter.
REQ-002 SHALL have parameter GAP_CYC, default 2, number of forced-low cycles after each output pulse; 0 is legal.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pulse_in  input  1  trigger; each cycle sampled high counts as one trigger event.
REQ-006 SHALL have port len  input  WIDTH  requested output high time in cycles, sampled at trigger.
REQ-007 SHALL have port retrig_en  input  1  1 = a trigger while high reloads the length.
REQ-008 SHALL have port level_out  output  1  stretched pulse, registered.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in IDLE, registered.
REQ-010 SHALL have port dropped  output  1  one-cycle flag: a trigger was ignored, registered.

Function
REQ-011 SHALL implement states IDLE, HIGH, GAP; level_out = 1 only in HIGH (Moore output, no combinational path from inputs).
REQ-012 IDLE, pulse_in=1, len!=0: SHALL go to HIGH and load counter = len-1; level_out is high in cycles k+1 .. k+len for a trigger in cycle k.
REQ-013 IDLE, pulse_in=1, len==0: SHALL stay in IDLE and assert dropped in the next cycle.
REQ-014 HIGH, no trigger: SHALL decrement the counter each cycle; at counter==0 it SHALL go to GAP if GAP_CYC>0, else to IDLE.
REQ-015 HIGH, pulse_in=1, retrig_en=1, len!=0: SHALL stay in HIGH and reload counter = len-1; level_out then remains high through cycle k+len with no low gap.
REQ-016 Retrigger in the cycle the counter reaches 0 SHALL take priority over exit to GAP/IDLE.
REQ-017 HIGH, pulse_in=1, and either retrig_en=0 or len==0: SHALL ignore the trigger, continue the count and assert dropped next cycle.
REQ-018 GAP: SHALL hold level_out=0 for exactly GAP_CYC cycles, then enter IDLE; every trigger in GAP, including the last GAP cycle, SHALL be dropped.
REQ-019 A trigger arriving in the first IDLE cycle after GAP SHALL be accepted per REQ-012.
REQ-020 Changes of len outside trigger cycles SHALL have no effect on the running count.
REQ-021 Counter arithmetic SHALL be unsigned WIDTH bits; the maximum len = 2^WIDTH-1 SHALL yield exactly that many high cycles, with no wrap.
REQ-022 The GAP counter SHALL be sized $clog2(GAP_CYC+1) bits, minimum 1.
REQ-023 dropped SHALL be high for exactly one cycle per ignored trigger; back-to-back ignored triggers SHALL keep it high continuously.

Reset
REQ-024 While rst=1: state=IDLE, counters=0, level_out=0, busy=0, dropped=0, all immediately (asynchronous).
REQ-025 Reset asserted mid-HIGH or mid-GAP SHALL abort the operation; after release the first trigger SHALL be treated per REQ-012.
REQ-026 A trigger in the same cycle that rst falls SHALL be accepted if sampled at a clock edge with rst low.

Structure
REQ-027 The state enum type pulse_state_t {IDLE, HIGH, GAP} SHALL live in shared package fsm_pkg.
REQ-028 The loadable down-counter (load, value, dec, zero flag) SHALL be sub-module pulse_down_cnt, instantiated once for the HIGH count.
REQ-029 The design SHALL use one state register process and one next-state/output-decode process, with a default assignment for every signal.

Verification
REQ-030 WIDTH=8, GAP_CYC=2, len=3, single pulse cycle 10 -> level_out high cycles 11-13, busy high 11-15, low from 16.
REQ-031 len=5, retrig_en=1, pulses cycles 10 and 13 -> level_out high continuously cycles 11-18, dropped never asserted.
REQ-032 len=5, retrig_en=0, pulses cycles 10 and 13 -> level_out high 11-15, dropped high cycle 14 only.
REQ-033 len=2, pulses cycles 10, 14 (in GAP), 15 (first IDLE) -> dropped at cycle 15; second high window cycles 16-17.
REQ-034 len=0 pulse -> no busy, dropped one cycle; len=255 -> exactly 255 high cycles.
REQ-035 rst pulsed during cycle 3 of HIGH -> level_out/busy low immediately; the next pulse gives a full-length window.
